// File: rtl/wb_reg_slave_pkg.sv
// wb_reg_slave_pkg: Wishbone cycle/burst codes and FSM encoding.
// WB_REG_SLAVE_BURST_EN adds the BURST state.
package wb_reg_slave_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

`ifdef WB_REG_SLAVE_BURST_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESP  = 2'd1,
    ST_BURST = 2'd2
  } state_t;
`else
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;
`endif

endpackage

// File: rtl/wb_reg_slave_addr_gen.sv
// wb_reg_slave_addr_gen: next burst word address and window overflow.
// Compiled only when WB_REG_SLAVE_BURST_EN is defined.
`ifdef WB_REG_SLAVE_BURST_EN
module wb_reg_slave_addr_gen
  import wb_reg_slave_pkg::*;
#(
  parameter int AW = 32,
  parameter int NUM_REGS = 4,
  parameter logic [AW-1:0] BASE_ADDRESS = 32'h9000_0000
) (
  input  logic [AW-3:0] i_wadr,
  input  logic [1:0]    i_bte,
  output logic [AW-3:0] o_wadr_nxt,
  output logic          o_ovf
);

  localparam int IW = $clog2(NUM_REGS);
  localparam int WW = AW - 2;

  logic [WW-1:0] w_inc;
  logic [WW-1:0] w_mask;

  assign w_inc = i_wadr + WW'(1);

  // Mask selects which word-address bits take the incremented value.
  always_comb begin
    w_mask = '1;
    unique case (i_bte)
      BTE_LINEAR: w_mask = '1;
      BTE_WRAP4:  w_mask = WW'(3);
      BTE_WRAP8:  w_mask = WW'(7);
      BTE_WRAP16: w_mask = WW'(15);
      default:    w_mask = '1;
    endcase
  end

  assign o_wadr_nxt = (i_wadr & ~w_mask) | (w_inc & w_mask);
  assign o_ovf = (o_wadr_nxt[WW-1:IW] != BASE_ADDRESS[AW-1:IW+2]);

endmodule
`endif

// File: rtl/wb_reg_slave.sv
// wb_reg_slave: Wishbone B4 register-file slave with decode and err response.
// Define WB_REG_SLAVE_BURST_EN for registered-feedback incrementing bursts.
module wb_reg_slave
  import wb_reg_slave_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int NUM_REGS = 4,
  parameter logic [AW-1:0] BASE_ADDRESS = 32'h9000_0000
) (
  input  logic                   wb_clk,
  input  logic                   wb_rst,
  input  logic [AW-1:0]          wb_adr_i,
  input  logic [DW-1:0]          wb_dat_i,
  input  logic [DW/8-1:0]        wb_sel_i,
  input  logic                   wb_we_i,
  input  logic                   wb_cyc_i,
  input  logic                   wb_stb_i,
  input  logic [2:0]             wb_cti_i,
  input  logic [1:0]             wb_bte_i,
  output logic [DW-1:0]          wb_dat_o,
  output logic                   wb_ack_o,
  output logic                   wb_err_o,
  output logic                   wb_rty_o,
  output logic [NUM_REGS*DW-1:0] reg_q_o,
  output logic [NUM_REGS-1:0]    wr_pulse_o
);

  localparam int IW = $clog2(NUM_REGS);
  localparam int NB = DW / 8;
`ifdef WB_REG_SLAVE_BURST_EN
  localparam int WAW = AW - 2;
`else
  localparam int WAW = IW;
`endif

  state_t r_state, w_state_nxt;

  logic [DW-1:0]       r_regs [NUM_REGS];
  logic [WAW-1:0]      r_wadr, w_wadr_nxt;
  logic [IW-1:0]       w_idx, w_rd_idx;
  logic [DW-1:0]       r_dat;
  logic [NUM_REGS-1:0] r_pulse;
  logic r_ack, w_ack_nxt;
  logic r_err, w_err_nxt;
  logic w_ld, w_rd_hit;
  logic w_req, w_req_hit;
  logic w_beat, w_wr;

  assign w_req = wb_cyc_i & wb_stb_i;
  assign w_req_hit =
    (wb_adr_i[AW-1:IW+2] == BASE_ADDRESS[AW-1:IW+2]) &&
    (wb_adr_i[1:0] == 2'b00);
  assign w_beat = r_ack & wb_cyc_i & wb_stb_i;
  assign w_wr = w_beat & wb_we_i;
  assign w_idx = r_wadr[IW-1:0];
  assign w_rd_idx = w_wadr_nxt[IW-1:0];

`ifdef WB_REG_SLAVE_BURST_EN
  logic [WAW-1:0] w_burst_nxt;
  logic           w_burst_ovf;
  logic           w_burst_req;

  wb_reg_slave_addr_gen #(
    .AW(AW),
    .NUM_REGS(NUM_REGS),
    .BASE_ADDRESS(BASE_ADDRESS)
  ) u_addr_gen (
    .i_wadr(r_wadr),
    .i_bte(wb_bte_i),
    .o_wadr_nxt(w_burst_nxt),
    .o_ovf(w_burst_ovf)
  );

  assign w_burst_req = (wb_cti_i == CTI_INCR);
`else
  logic w_unused;
  assign w_unused = ^{wb_cti_i, wb_bte_i};
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt = 1'b0;
    w_err_nxt = 1'b0;
    w_ld = 1'b0;
    w_rd_hit = 1'b0;
    w_wadr_nxt = r_wadr;
    unique case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_ld = 1'b1;
          w_wadr_nxt = wb_adr_i[WAW+1:2];
          w_rd_hit = w_req_hit;
          w_ack_nxt = w_req_hit;
          w_err_nxt = !w_req_hit;
          w_state_nxt = ST_RESP;
`ifdef WB_REG_SLAVE_BURST_EN
          if (w_req_hit && w_burst_req)
            w_state_nxt = ST_BURST;
`endif
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
`ifdef WB_REG_SLAVE_BURST_EN
      ST_BURST: begin
        if (!wb_cyc_i) begin
          w_state_nxt = ST_IDLE;
        end else if (w_beat) begin
          if (!w_burst_req) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_ld = 1'b1;
            w_wadr_nxt = w_burst_nxt;
            w_rd_hit = !w_burst_ovf;
            w_ack_nxt = !w_burst_ovf;
            w_err_nxt = w_burst_ovf;
            if (w_burst_ovf)
              w_state_nxt = ST_RESP;
          end
        end else begin
          // Wait state: address and data hold, ack follows stb.
          w_ack_nxt = wb_stb_i;
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      r_state <= ST_IDLE;
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_dat <= '0;
      r_wadr <= '0;
      r_pulse <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ack <= w_ack_nxt;
      r_err <= w_err_nxt;
      if (w_ld) begin
        r_wadr <= w_wadr_nxt;
        r_dat <= w_rd_hit ? r_regs[w_rd_idx] : '0;
      end
      r_pulse <= '0;
      if (w_wr)
        r_pulse[w_idx] <= 1'b1;
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        r_regs[i] <= '0;
    end else if (w_wr) begin
      for (int b = 0; b < NB; b++)
        if (wb_sel_i[b])
          r_regs[w_idx][b*8 +: 8] <= wb_dat_i[b*8 +: 8];
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_q
    assign reg_q_o[g*DW +: DW] = r_regs[g];
  end

  assign wb_dat_o = r_dat;
  assign wb_ack_o = r_ack;
  assign wb_err_o = r_err;
  assign wb_rty_o = 1'b0;
  assign wr_pulse_o = r_pulse;

endmodule

// File: tb/tb_wb_reg_slave.sv
// tb_wb_reg_slave: directed self-checking bench for wb_reg_slave.
// Burst scenarios are compiled when WB_REG_SLAVE_BURST_EN is defined.
`timescale 1ns/1ps
module tb_wb_reg_slave;

  logic         wb_clk = 1'b0;
  logic         wb_rst;
  logic [31:0]  wb_adr_i;
  logic [31:0]  wb_dat_i;
  logic [3:0]   wb_sel_i;
  logic         wb_we_i;
  logic         wb_cyc_i;
  logic         wb_stb_i;
  logic [2:0]   wb_cti_i;
  logic [1:0]   wb_bte_i;
  logic [31:0]  wb_dat_o;
  logic         wb_ack_o;
  logic         wb_err_o;
  logic         wb_rty_o;
  logic [127:0] reg_q_o;
  logic [3:0]   wr_pulse_o;

  int n_run = 0;
  int n_fail = 0;
  logic [127:0] q_exp;

  always #5 wb_clk = ~wb_clk;

  wb_reg_slave #(
    .DW(32),
    .AW(32),
    .NUM_REGS(4),
    .BASE_ADDRESS(32'h9000_0000)
  ) dut (
    .wb_clk(wb_clk),
    .wb_rst(wb_rst),
    .wb_adr_i(wb_adr_i),
    .wb_dat_i(wb_dat_i),
    .wb_sel_i(wb_sel_i),
    .wb_we_i(wb_we_i),
    .wb_cyc_i(wb_cyc_i),
    .wb_stb_i(wb_stb_i),
    .wb_cti_i(wb_cti_i),
    .wb_bte_i(wb_bte_i),
    .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o),
    .wb_err_o(wb_err_o),
    .wb_rty_o(wb_rty_o),
    .reg_q_o(reg_q_o),
    .wr_pulse_o(wr_pulse_o)
  );

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic idle_bus();
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i = 1'b0;
    wb_cti_i = 3'b000;
    wb_bte_i = 2'b00;
    wb_sel_i = 4'h0;
    wb_adr_i = 32'h0;
    wb_dat_i = 32'h0;
  endtask

  task automatic req(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic we,
                     input logic [2:0] cti, input logic [1:0] bte);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_adr_i = a;
    wb_dat_i = d;
    wb_sel_i = s;
    wb_we_i = we;
    wb_cti_i = cti;
    wb_bte_i = bte;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_run++;
    if (wb_ack_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_ack: got %b expected 0", wb_ack_o);
    end
    n_run++;
    if (wb_err_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_err: got %b expected 0", wb_err_o);
    end
    n_run++;
    if (wb_rty_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_rty: got %b expected 0", wb_rty_o);
    end
    n_run++;
    if (wb_dat_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_dat: got %h expected 0", wb_dat_o);
    end
    n_run++;
    if (reg_q_o !== 128'h0) begin
      n_fail++; $display("FAIL reset_q: got %h expected 0", reg_q_o);
    end
    n_run++;
    if (wr_pulse_o !== 4'h0) begin
      n_fail++; $display("FAIL reset_pulse: got %b expected 0", wr_pulse_o);
    end
    wb_rst = 1'b1;
    tick();
  endtask

  task automatic test_classic_write();
    logic [31:0] va [3] = '{32'h9000_0004, 32'h9000_0000, 32'h9000_000C};
    logic [31:0] vd [3] = '{32'hDEAD_BEEF, 32'h1234_5678, 32'hA5A5_5A5A};
    logic [3:0]  vs [3] = '{4'b0011, 4'b1111, 4'b1100};
    logic [3:0]  vp [3] = '{4'b0010, 4'b0001, 4'b1000};
    for (int i = 0; i < 3; i++) begin
      req(va[i], vd[i], vs[i], 1'b1, 3'b000, 2'b00);
      tick();
      n_run++;
      if (wb_ack_o !== 1'b1 || wb_err_o !== 1'b0) begin
        n_fail++;
        $display("FAIL wr_ack[%0d]: got ack=%b err=%b expected 1/0",
                 i, wb_ack_o, wb_err_o);
      end
      tick();
      n_run++;
      if (wb_ack_o !== 1'b0 || wr_pulse_o !== vp[i]) begin
        n_fail++;
        $display("FAIL wr_pulse[%0d]: got ack=%b pulse=%b expected 0/%b",
                 i, wb_ack_o, wr_pulse_o, vp[i]);
      end
      idle_bus();
      tick();
      n_run++;
      if (wr_pulse_o !== 4'h0) begin
        n_fail++;
        $display("FAIL wr_pulse_clr[%0d]: got %b expected 0", i, wr_pulse_o);
      end
    end
    q_exp = {32'hA5A5_0000, 32'h0, 32'h0000_BEEF, 32'h1234_5678};
    n_run++;
    if (reg_q_o !== q_exp) begin
      n_fail++; $display("FAIL wr_regs: got %h expected %h", reg_q_o, q_exp);
    end
  endtask

  task automatic test_classic_read();
    logic [31:0] va [3] = '{32'h9000_0004, 32'h9000_0000, 32'h9000_000C};
    logic [31:0] ve [3] = '{32'h0000_BEEF, 32'h1234_5678, 32'hA5A5_0000};
    for (int i = 0; i < 3; i++) begin
      req(va[i], 32'h0, 4'hF, 1'b0, 3'b000, 2'b00);
      tick();
      n_run++;
      if (wb_ack_o !== 1'b1 || wb_dat_o !== ve[i]) begin
        n_fail++;
        $display("FAIL rd[%0d]: got ack=%b dat=%h expected 1/%h",
                 i, wb_ack_o, wb_dat_o, ve[i]);
      end
      tick();
      n_run++;
      if (wb_ack_o !== 1'b0 || wb_dat_o !== ve[i]) begin
        n_fail++;
        $display("FAIL rd_hold[%0d]: got ack=%b dat=%h expected 0/%h",
                 i, wb_ack_o, wb_dat_o, ve[i]);
      end
      idle_bus();
      tick();
    end
  endtask

  task automatic test_sel_zero();
    req(32'h9000_0008, 32'hFFFF_FFFF, 4'b0000, 1'b1, 3'b000, 2'b00);
    tick();
    n_run++;
    if (wb_ack_o !== 1'b1) begin
      n_fail++; $display("FAIL sel0_ack: got %b expected 1", wb_ack_o);
    end
    tick();
    n_run++;
    if (wr_pulse_o !== 4'b0100 || reg_q_o !== q_exp) begin
      n_fail++;
      $display("FAIL sel0: got pulse=%b q=%h expected 0100/%h",
               wr_pulse_o, reg_q_o, q_exp);
    end
    idle_bus();
    tick();
  endtask

  task automatic test_err();
    logic [31:0] va [3] = '{32'h9000_0010, 32'h9000_0002, 32'h8000_0004};
    logic        vw [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      req(va[i], 32'h1111_1111, 4'hF, vw[i], 3'b000, 2'b00);
      tick();
      n_run++;
      if (wb_err_o !== 1'b1 || wb_ack_o !== 1'b0 || wb_dat_o !== 32'h0) begin
        n_fail++;
        $display("FAIL err[%0d]: got err=%b ack=%b dat=%h expected 1/0/0",
                 i, wb_err_o, wb_ack_o, wb_dat_o);
      end
      tick();
      n_run++;
      if (wb_err_o !== 1'b0 || wr_pulse_o !== 4'h0 || reg_q_o !== q_exp) begin
        n_fail++;
        $display("FAIL err_after[%0d]: got err=%b pulse=%b q=%h expected 0/0/%h",
                 i, wb_err_o, wr_pulse_o, reg_q_o, q_exp);
      end
      idle_bus();
      tick();
    end
  endtask

  task automatic test_cyc_drop();
    req(32'h9000_0008, 32'h7777_7777, 4'hF, 1'b1, 3'b000, 2'b00);
    tick();
    n_run++;
    if (wb_ack_o !== 1'b1) begin
      n_fail++; $display("FAIL drop_ack: got %b expected 1", wb_ack_o);
    end
    idle_bus();
    tick();
    n_run++;
    if (wb_ack_o !== 1'b0 || wr_pulse_o !== 4'h0 || reg_q_o !== q_exp) begin
      n_fail++;
      $display("FAIL drop: got ack=%b pulse=%b q=%h expected 0/0/%h",
               wb_ack_o, wr_pulse_o, reg_q_o, q_exp);
    end
    tick();
  endtask

`ifdef WB_REG_SLAVE_BURST_EN
  task automatic test_burst_linear();
    logic [3:0] pe;
    req(32'h9000_0000, 32'h1, 4'hF, 1'b1, 3'b010, 2'b00);
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k > 0) begin
        wb_dat_i = 32'(k + 1);
        wb_adr_i = 32'h0BAD_0000;
        wb_cti_i = (k == 3) ? 3'b111 : 3'b010;
        pe = 4'b0001 << (k - 1);
        n_run++;
        if (wr_pulse_o !== pe) begin
          n_fail++;
          $display("FAIL bl_pulse[%0d]: got %b expected %b", k, wr_pulse_o, pe);
        end
      end
      n_run++;
      if (wb_ack_o !== 1'b1 || wb_err_o !== 1'b0) begin
        n_fail++;
        $display("FAIL bl_ack[%0d]: got ack=%b err=%b expected 1/0",
                 k, wb_ack_o, wb_err_o);
      end
    end
    tick();
    idle_bus();
    q_exp = {32'h4, 32'h3, 32'h2, 32'h1};
    n_run++;
    if (wb_ack_o !== 1'b0 || wr_pulse_o !== 4'b1000 || reg_q_o !== q_exp) begin
      n_fail++;
      $display("FAIL bl_end: got ack=%b pulse=%b q=%h expected 0/1000/%h",
               wb_ack_o, wr_pulse_o, reg_q_o, q_exp);
    end
    tick();
    n_run++;
    if (wb_ack_o !== 1'b0) begin
      n_fail++; $display("FAIL bl_idle: got %b expected 0", wb_ack_o);
    end
  endtask

  task automatic test_burst_wrap();
    logic [31:0] ve [4] = '{32'h3, 32'h4, 32'h1, 32'h2};
    req(32'h9000_0008, 32'h0, 4'hF, 1'b0, 3'b010, 2'b01);
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 3)
        wb_cti_i = 3'b111;
      n_run++;
      if (wb_ack_o !== 1'b1 || wb_dat_o !== ve[k]) begin
        n_fail++;
        $display("FAIL bw[%0d]: got ack=%b dat=%h expected 1/%h",
                 k, wb_ack_o, wb_dat_o, ve[k]);
      end
    end
    tick();
    idle_bus();
    n_run++;
    if (wb_ack_o !== 1'b0) begin
      n_fail++; $display("FAIL bw_end: got %b expected 0", wb_ack_o);
    end
    tick();
  endtask

  task automatic test_burst_overflow();
    req(32'h9000_000C, 32'h0, 4'hF, 1'b0, 3'b010, 2'b00);
    tick();
    n_run++;
    if (wb_ack_o !== 1'b1 || wb_dat_o !== 32'h4) begin
      n_fail++;
      $display("FAIL bo_first: got ack=%b dat=%h expected 1/4",
               wb_ack_o, wb_dat_o);
    end
    tick();
    n_run++;
    if (wb_err_o !== 1'b1 || wb_ack_o !== 1'b0 || wb_dat_o !== 32'h0) begin
      n_fail++;
      $display("FAIL bo_err: got err=%b ack=%b dat=%h expected 1/0/0",
               wb_err_o, wb_ack_o, wb_dat_o);
    end
    idle_bus();
    tick();
    n_run++;
    if (wb_err_o !== 1'b0 || wb_ack_o !== 1'b0) begin
      n_fail++;
      $display("FAIL bo_end: got err=%b ack=%b expected 0/0",
               wb_err_o, wb_ack_o);
    end
  endtask

  task automatic test_burst_wait();
    req(32'h9000_0000, 32'h0, 4'hF, 1'b0, 3'b010, 2'b00);
    tick();
    n_run++;
    if (wb_ack_o !== 1'b1 || wb_dat_o !== 32'h1) begin
      n_fail++;
      $display("FAIL bwt0: got ack=%b dat=%h expected 1/1", wb_ack_o, wb_dat_o);
    end
    tick();
    wb_stb_i = 1'b0;
    n_run++;
    if (wb_ack_o !== 1'b1 || wb_dat_o !== 32'h2) begin
      n_fail++;
      $display("FAIL bwt1: got ack=%b dat=%h expected 1/2", wb_ack_o, wb_dat_o);
    end
    tick();
    wb_stb_i = 1'b1;
    n_run++;
    if (wb_ack_o !== 1'b0 || wb_dat_o !== 32'h2) begin
      n_fail++;
      $display("FAIL bwt_wait: got ack=%b dat=%h expected 0/2",
               wb_ack_o, wb_dat_o);
    end
    tick();
    wb_cti_i = 3'b111;
    n_run++;
    if (wb_ack_o !== 1'b1 || wb_dat_o !== 32'h2) begin
      n_fail++;
      $display("FAIL bwt_resume: got ack=%b dat=%h expected 1/2",
               wb_ack_o, wb_dat_o);
    end
    tick();
    idle_bus();
    n_run++;
    if (wb_ack_o !== 1'b0) begin
      n_fail++; $display("FAIL bwt_end: got %b expected 0", wb_ack_o);
    end
    tick();
  endtask
`else
  task automatic test_no_burst();
    logic ve [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    req(32'h9000_0008, 32'h42, 4'hF, 1'b1, 3'b010, 2'b00);
    for (int k = 0; k < 4; k++) begin
      tick();
      n_run++;
      if (wb_ack_o !== ve[k]) begin
        n_fail++;
        $display("FAIL nb_ack[%0d]: got %b expected %b", k, wb_ack_o, ve[k]);
      end
    end
    idle_bus();
    tick();
    q_exp[95:64] = 32'h42;
    n_run++;
    if (reg_q_o !== q_exp) begin
      n_fail++; $display("FAIL nb_regs: got %h expected %h", reg_q_o, q_exp);
    end
  endtask
`endif

  task automatic test_reset_mid();
    req(32'h9000_0004, 32'h5555_5555, 4'hF, 1'b1, 3'b010, 2'b00);
    tick();
    n_run++;
    if (wb_ack_o !== 1'b1) begin
      n_fail++; $display("FAIL rm_ack: got %b expected 1", wb_ack_o);
    end
    #2;
    wb_rst = 1'b0;
    #1;
    n_run++;
    if (wb_ack_o !== 1'b0 || wb_err_o !== 1'b0 || wb_dat_o !== 32'h0) begin
      n_fail++;
      $display("FAIL rm_out: got ack=%b err=%b dat=%h expected 0/0/0",
               wb_ack_o, wb_err_o, wb_dat_o);
    end
    n_run++;
    if (reg_q_o !== 128'h0 || wr_pulse_o !== 4'h0) begin
      n_fail++;
      $display("FAIL rm_regs: got q=%h pulse=%b expected 0/0",
               reg_q_o, wr_pulse_o);
    end
    idle_bus();
    tick();
    wb_rst = 1'b1;
    tick();
    n_run++;
    if (wb_ack_o !== 1'b0 || wb_err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_idle: got ack=%b err=%b expected 0/0",
               wb_ack_o, wb_err_o);
    end
    req(32'h9000_0004, 32'h0, 4'hF, 1'b0, 3'b000, 2'b00);
    tick();
    n_run++;
    if (wb_ack_o !== 1'b1 || wb_dat_o !== 32'h0) begin
      n_fail++;
      $display("FAIL rm_read: got ack=%b dat=%h expected 1/0",
               wb_ack_o, wb_dat_o);
    end
    idle_bus();
    tick();
  endtask

  initial begin
    wb_rst = 1'b0;
    idle_bus();
    q_exp = '0;
    test_reset();
    test_classic_write();
    test_classic_read();
    test_sel_zero();
    test_err();
    test_cyc_drop();
`ifdef WB_REG_SLAVE_BURST_EN
    test_burst_linear();
    test_burst_wrap();
    test_burst_overflow();
    test_burst_wait();
`else
    test_no_burst();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
